// File: rtl/ucode_fetch_arbiter.sv
// Steers decode between the fetch stream and the microcode sequencer for MUL* ops.
// Pass-through is combinational; a MUL stalls the PC until the sequencer releases or times out.
module ucode_fetch_arbiter #(
    parameter logic [6:0]  MULI_OP  = 7'b1000000,
    parameter logic [6:0]  MULR_OP  = 7'b1000001,
    parameter logic [6:0]  MULSI_OP = 7'b1000010,
    parameter logic [6:0]  MULSR_OP = 7'b1000011,
    parameter logic [15:0] WDOG_MAX = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        flush,
    input  logic [31:0] uc_instr,
    input  logic        uc_mux_ctrl,
    input  logic        uc_release,
    input  logic [3:0]  uc_flags,
    output logic        start_mul,
    output logic [3:0]  mul_dest,
    output logic [3:0]  mul_src,
    output logic [3:0]  mul_rs2,
    output logic [15:0] mul_imm,
    output logic [1:0]  mul_type,
    output logic        pc_stall,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        flags_restore,
    output logic [3:0]  flags_restore_val,
    output logic [15:0] uc_count,
    output logic        wdog_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_RESUME = 2'd3
    } state_t;

    localparam logic [31:0] NOP = {5'b11001, 27'b0};

    state_t      state_q, state_d;
    logic [3:0]  dest_q, dest_d;
    logic [3:0]  src_q, src_d;
    logic [3:0]  rs2_q, rs2_d;
    logic [15:0] imm_q, imm_d;
    logic [1:0]  type_q, type_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] wdog_q, wdog_d;
    logic        err_q, err_d;

    logic [6:0]  opcode;
    logic        is_mul;
    logic [1:0]  dec_type;
    logic [16:0] wdog_inc;

    assign opcode   = if_instr[31:25];
    assign wdog_inc = {1'b0, wdog_q} + 17'd1;

    always_comb begin
        is_mul   = 1'b1;
        dec_type = 2'd0;
        if (opcode == MULI_OP)       dec_type = 2'd0;
        else if (opcode == MULR_OP)  dec_type = 2'd1;
        else if (opcode == MULSI_OP) dec_type = 2'd2;
        else if (opcode == MULSR_OP) dec_type = 2'd3;
        else                         is_mul   = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dest_q  <= 4'd0;
            src_q   <= 4'd0;
            rs2_q   <= 4'd0;
            imm_q   <= 16'd0;
            type_q  <= 2'd0;
            cnt_q   <= 16'd0;
            wdog_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        dest_d            = dest_q;
        src_d             = src_q;
        rs2_d             = rs2_q;
        imm_d             = imm_q;
        type_d            = type_q;
        cnt_d             = cnt_q;
        wdog_d            = wdog_q;
        err_d             = err_q;
        start_mul         = 1'b0;
        pc_stall          = 1'b0;
        id_instr          = NOP;
        id_valid          = 1'b0;
        flags_restore     = 1'b0;
        flags_restore_val = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    // squashed slot: no decode, no MUL detection
                end else if (if_valid && is_mul) begin
                    dest_d   = if_instr[24:21];
                    src_d    = if_instr[20:17];
                    rs2_d    = if_instr[16:13];
                    imm_d    = if_instr[15:0];
                    type_d   = dec_type;
                    cnt_d    = 16'd0;
                    pc_stall = 1'b1;
                    state_d  = S_LAUNCH;
                end else begin
                    id_instr = if_instr;
                    id_valid = if_valid;
                end
            end
            S_LAUNCH: begin
                start_mul = 1'b1;
                pc_stall  = 1'b1;
                wdog_d    = 16'd0;
                state_d   = S_BUSY;
            end
            S_BUSY: begin
                pc_stall = 1'b1;
                wdog_d   = wdog_inc[15:0];
                if (uc_mux_ctrl) begin
                    id_instr = uc_instr;
                    id_valid = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end
                // a release in the same cycle as the timeout still restores flags
                if (uc_release) begin
                    flags_restore     = 1'b1;
                    flags_restore_val = uc_flags;
                    state_d           = S_RESUME;
                end else if (wdog_inc >= {1'b0, WDOG_MAX}) begin
                    err_d   = 1'b1;
                    state_d = S_RESUME;
                end
            end
            S_RESUME: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            start_mul         = 1'b0;
            pc_stall          = 1'b0;
            id_valid          = 1'b0;
            flags_restore     = 1'b0;
            flags_restore_val = 4'd0;
        end
    end

    assign mul_dest = dest_q;
    assign mul_src  = src_q;
    assign mul_rs2  = rs2_q;
    assign mul_imm  = imm_q;
    assign mul_type = type_q;
    assign uc_count = cnt_q;
    assign wdog_err = err_q;

endmodule

// File: tb/tb_ucode_fetch_arbiter.sv
// Directed bench for ucode_fetch_arbiter: sequence-level model checked every negedge,
// plus literal expectations at key points of each scenario.
module tb_ucode_fetch_arbiter;

    localparam int          WD      = 8;
    localparam logic [6:0]  OP_MULI = 7'b1000000;
    localparam logic [6:0]  OP_MULR = 7'b1000001;
    localparam logic [6:0]  OP_MULSI = 7'b1000010;
    localparam logic [6:0]  OP_MULSR = 7'b1000011;
    localparam logic [31:0] NOP     = 32'hC800_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        flush;
    logic [31:0] uc_instr;
    logic        uc_mux_ctrl;
    logic        uc_release;
    logic [3:0]  uc_flags;
    logic        start_mul;
    logic [3:0]  mul_dest, mul_src, mul_rs2;
    logic [15:0] mul_imm;
    logic [1:0]  mul_type;
    logic        pc_stall;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flags_restore;
    logic [3:0]  flags_restore_val;
    logic [15:0] uc_count;
    logic        wdog_err;

    int n_checks = 0;
    int n_pass   = 0;

    ucode_fetch_arbiter #(.WDOG_MAX(16'd8)) dut (
        .clk(clk), .rst(rst),
        .if_instr(if_instr), .if_valid(if_valid), .flush(flush),
        .uc_instr(uc_instr), .uc_mux_ctrl(uc_mux_ctrl),
        .uc_release(uc_release), .uc_flags(uc_flags),
        .start_mul(start_mul),
        .mul_dest(mul_dest), .mul_src(mul_src), .mul_rs2(mul_rs2),
        .mul_imm(mul_imm), .mul_type(mul_type),
        .pc_stall(pc_stall), .id_instr(id_instr), .id_valid(id_valid),
        .flags_restore(flags_restore), .flags_restore_val(flags_restore_val),
        .uc_count(uc_count), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic drv(input logic [31:0] ins, input int v, input int fl,
                       input logic [31:0] uci, input int mux, input int rel, input int flg);
        if_instr    = ins;
        if_valid    = (v != 0);
        flush       = (fl != 0);
        uc_instr    = uci;
        uc_mux_ctrl = (mux != 0);
        uc_release  = (rel != 0);
        uc_flags    = 4'(flg);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sequence-level model: m_k = 0 idle, 1 launch, 2 sequencer running; m_res = resume slot
    int          m_k = 0;
    bit          m_res = 1'b0;
    int          m_busy = 0;
    logic [3:0]  m_dest = '0, m_src = '0, m_rs2 = '0;
    logic [15:0] m_imm = '0, m_cnt = '0;
    logic [1:0]  m_type = '0;
    bit          m_err = 1'b0;
    logic        e_start, e_stall, e_v, e_fr;
    logic [31:0] e_id;
    logic [3:0]  e_frv;
    logic [6:0]  op_off;

    always @(negedge clk) begin
        if (rst) begin
            m_k = 0; m_res = 1'b0; m_busy = 0;
            m_dest = '0; m_src = '0; m_rs2 = '0; m_imm = '0; m_type = '0;
            m_cnt = '0; m_err = 1'b0;
        end
        chk("mul_dest", 32'(mul_dest), 32'(m_dest));
        chk("mul_src",  32'(mul_src),  32'(m_src));
        chk("mul_rs2",  32'(mul_rs2),  32'(m_rs2));
        chk("mul_imm",  32'(mul_imm),  32'(m_imm));
        chk("mul_type", 32'(mul_type), 32'(m_type));
        chk("uc_count", 32'(uc_count), 32'(m_cnt));
        chk("wdog_err", 32'(wdog_err), 32'(m_err));

        e_start = 1'b0; e_stall = 1'b0; e_v = 1'b0; e_fr = 1'b0; e_id = NOP; e_frv = 4'd0;
        if (!rst) begin
            if (m_res) begin
                m_res = 1'b0;
            end else if (m_k == 0) begin
                if (flush) begin
                end else if (if_valid && (if_instr[31:25] inside {OP_MULI, OP_MULR, OP_MULSI, OP_MULSR})) begin
                    e_stall = 1'b1;
                    m_k     = 1;
                    m_dest  = if_instr[24:21];
                    m_src   = if_instr[20:17];
                    m_rs2   = if_instr[16:13];
                    m_imm   = if_instr[15:0];
                    op_off  = if_instr[31:25] - OP_MULI;
                    m_type  = op_off[1:0];
                    m_cnt   = '0;
                end else begin
                    e_id = if_instr;
                    e_v  = if_valid;
                end
            end else if (m_k == 1) begin
                e_start = 1'b1;
                e_stall = 1'b1;
                m_k     = 2;
                m_busy  = 0;
            end else begin
                e_stall = 1'b1;
                m_busy  = m_busy + 1;
                if (uc_mux_ctrl) begin
                    e_id = uc_instr;
                    e_v  = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                if (uc_release) begin
                    e_fr  = 1'b1;
                    e_frv = uc_flags;
                    m_k   = 0;
                    m_res = 1'b1;
                end else if (m_busy == WD) begin
                    m_err = 1'b1;
                    m_k   = 0;
                    m_res = 1'b1;
                end
            end
            chk("id_instr", id_instr, e_id);
        end
        chk("start_mul",     32'(start_mul),     32'(e_start));
        chk("pc_stall",      32'(pc_stall),      32'(e_stall));
        chk("id_valid",      32'(id_valid),      32'(e_v));
        chk("flags_restore", 32'(flags_restore), 32'(e_fr));
        if (e_fr) chk("flags_restore_val", 32'(flags_restore_val), 32'(e_frv));
    end

    logic [31:0] i_muli, i_mulsr, i_mulr, i_mulsi;

    initial begin
        i_muli  = {OP_MULI, 4'd1, 4'd0, 17'd3};
        i_mulsr = {OP_MULSR, 4'd5, 4'd6, 17'h1_2345};
        i_mulr  = {OP_MULR, 4'd2, 4'd3, 17'h0_0044};
        i_mulsi = {OP_MULSI, 4'd9, 4'd8, 17'h1_F00D};

        rst = 1'b1;
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0);
        #2;
        chk("rst_start_mul", 32'(start_mul), 32'h0);
        chk("rst_pc_stall", 32'(pc_stall), 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_uc_count", 32'(uc_count), 32'h0);
        chk("rst_wdog_err", 32'(wdog_err), 32'h0);
        tick();
        rst = 1'b0;

        // plain pass-through
        drv(32'h1234_5678, 1, 0, 32'h0, 0, 0, 0); #1;
        chk("pass_instr", id_instr, 32'h1234_5678);
        chk("pass_valid", 32'(id_valid), 32'h1);
        chk("pass_stall", 32'(pc_stall), 32'h0);
        tick();
        // release outside a sequence is ignored
        drv(32'h0000_0042, 1, 0, 32'h0, 0, 1, 15); #1;
        chk("idle_release", 32'(flags_restore), 32'h0);
        tick();

        // MULI with 4 injected instructions
        drv(i_muli, 1, 0, 32'h0, 0, 0, 0); #1;
        chk("muli_detect_stall", 32'(pc_stall), 32'h1);
        chk("muli_detect_instr", id_instr, NOP);
        tick();
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); #1;
        chk("muli_start", 32'(start_mul), 32'h1);
        chk("muli_imm", 32'(mul_imm), 32'h3);
        chk("muli_type", 32'(mul_type), 32'h0);
        chk("muli_dest", 32'(mul_dest), 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(32'h0, 0, 0, 32'hA000_0000 + 32'(i), 1, 0, 0); #1;
            chk("muli_fwd", id_instr, 32'hA000_0000 + 32'(i));
            tick();
        end
        drv(32'h0, 0, 0, 32'h0, 0, 1, 10); #1;
        chk("muli_restore", 32'(flags_restore), 32'h1);
        chk("muli_flags", 32'(flags_restore_val), 32'hA);
        chk("muli_count", 32'(uc_count), 32'h4);
        tick();
        // release held into RESUME must not re-pulse
        drv(32'h0, 0, 0, 32'h0, 0, 1, 10); #1;
        chk("muli_resume_stall", 32'(pc_stall), 32'h0);
        chk("muli_restore_once", 32'(flags_restore), 32'h0);
        tick();

        // MULSR with flush held during the sequence; release with last injection
        drv(i_mulsr, 1, 0, 32'h0, 0, 0, 0); tick();
        drv(32'h0, 0, 1, 32'h0, 0, 0, 0); #1;
        chk("mulsr_type", 32'(mul_type), 32'h3);
        chk("mulsr_rs2", 32'(mul_rs2), 32'h9);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(32'h0, 0, 1, 32'hB000_0000 + 32'(i), 1, (i == 2) ? 1 : 0, 5); #1;
            chk("mulsr_fwd_valid", 32'(id_valid), 32'h1);
            tick();
        end
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); #1;
        chk("mulsr_count", 32'(uc_count), 32'h3);
        tick();

        // MUL under flush in IDLE is squashed
        drv(i_mulr, 1, 1, 32'h0, 0, 0, 0); #1;
        chk("flush_valid", 32'(id_valid), 32'h0);
        chk("flush_stall", 32'(pc_stall), 32'h0);
        tick();
        drv(32'h0000_0007, 0, 0, 32'h0, 0, 0, 0); #1;
        chk("flush_no_start", 32'(start_mul), 32'h0);
        tick();

        // watchdog: no release for WD busy cycles
        drv(i_mulsi, 1, 0, 32'h0, 0, 0, 0); tick();
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); tick();
        for (int i = 0; i < WD; i++) begin
            drv(32'h0, 0, 0, 32'hC000_0000 + 32'(i), (i % 3 == 0) ? 1 : 0, 0, 0); #1;
            chk("wdog_pending", 32'(wdog_err), 32'h0);
            tick();
        end
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); #1;
        chk("wdog_set", 32'(wdog_err), 32'h1);
        chk("wdog_resume_stall", 32'(pc_stall), 32'h0);
        chk("wdog_no_restore", 32'(flags_restore), 32'h0);
        chk("wdog_count", 32'(uc_count), 32'h3);
        tick();
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); #1;
        chk("wdog_sticky", 32'(wdog_err), 32'h1);
        tick();

        // reset in the middle of a sequence
        drv(i_muli, 1, 0, 32'h0, 0, 0, 0); tick();
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); tick();
        drv(32'h0, 0, 0, 32'hD000_0000, 1, 0, 0); tick();
        drv(32'h0, 0, 0, 32'hD000_0001, 1, 0, 0); #1;
        rst = 1'b1; #1;
        chk("rst_busy_stall", 32'(pc_stall), 32'h0);
        chk("rst_busy_wdog", 32'(wdog_err), 32'h0);
        chk("rst_busy_count", 32'(uc_count), 32'h0);
        tick();
        rst = 1'b0;
        drv(i_mulr, 1, 0, 32'h0, 0, 0, 0); #1;
        chk("relaunch_stall", 32'(pc_stall), 32'h1);
        tick();
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); #1;
        chk("relaunch_start", 32'(start_mul), 32'h1);
        chk("relaunch_type", 32'(mul_type), 32'h1);
        tick();
        drv(32'h0, 0, 0, 32'hE000_0000, 1, 1, 3); tick();
        drv(32'h0, 0, 0, 32'h0, 0, 0, 0); tick();
        drv(32'h5555_0000, 1, 0, 32'h0, 0, 0, 0); tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
